// File: rtl/versioned_store_pkg.sv
// Shared types and helpers for the versioned store: default widths, the slot
// record layout and the occupancy counter width.
package versioned_store_pkg;

  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_VERSION_WIDTH = 4;

  typedef struct packed {
    logic                         valid;
    logic [DEF_VERSION_WIDTH-1:0] version;
    logic [DEF_DATA_WIDTH-1:0]    data;
  } slotT;

  // Occupancy counts 0..numSlots inclusive, so it needs one more state than an index.
  function automatic int occWidth(input int numSlots);
    return $clog2(numSlots + 1);
  endfunction

endpackage

// File: rtl/version_select.sv
// Combinational search for the valid slot holding the largest version that
// does not exceed the key. Versions are unique, so no tie-break is needed.
module version_select #(
  parameter  int NUM_SLOTS     = 4,
  parameter  int VERSION_WIDTH = 4,
  localparam int IDX_W         = $clog2(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS-1:0]                    slotValid,
  input  logic [NUM_SLOTS-1:0][VERSION_WIDTH-1:0] slotVersion,
  input  logic [VERSION_WIDTH-1:0]                key,
  output logic                                    hit,
  output logic [IDX_W-1:0]                        index,
  output logic [VERSION_WIDTH-1:0]                version
);

  always_comb begin
    hit     = 1'b0;
    index   = '0;
    version = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slotValid[i] && (slotVersion[i] <= key) && (!hit || (slotVersion[i] > version))) begin
        hit     = 1'b1;
        index   = IDX_W'(i);
        version = slotVersion[i];
      end
    end
  end

endmodule

// File: rtl/versioned_store.sv
// Multi-version store for one logical value: allocating writes, version-qualified
// reads with one cycle latency, and release-driven garbage collection.
module versioned_store
  import versioned_store_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int VERSION_WIDTH = DEF_VERSION_WIDTH,
  parameter int NUM_SLOTS     = 4,
  parameter bit EVICT_OLDEST  = 1'b0
) (
  input  logic                               clk,
  input  logic                               rstN,
  input  logic                               wrValid,
  output logic                               wrReady,
  input  logic [VERSION_WIDTH-1:0]           wrVersion,
  input  logic [DATA_WIDTH-1:0]              wrData,
  input  logic                               rdValid,
  input  logic [VERSION_WIDTH-1:0]           rdVersion,
  output logic                               rdRespValid,
  output logic                               rdHit,
  output logic [DATA_WIDTH-1:0]              rdData,
  output logic [VERSION_WIDTH-1:0]           rdMatchVersion,
  input  logic                               relValid,
  input  logic [VERSION_WIDTH-1:0]           relVersion,
  output logic [occWidth(NUM_SLOTS)-1:0]     occupancy
);

  localparam int IDX_W = $clog2(NUM_SLOTS);
  localparam int OCC_W = occWidth(NUM_SLOTS);

  logic [NUM_SLOTS-1:0]                    slotValid;
  logic [NUM_SLOTS-1:0]                    validNext;
  logic [NUM_SLOTS-1:0][VERSION_WIDTH-1:0] slotVersion;
  logic [DATA_WIDTH-1:0]                   slotData [NUM_SLOTS];

  logic             matchHit, freeHit, oldestFound;
  logic [IDX_W-1:0] matchIdx, freeIdx, oldestIdx, wrIdx;
  logic [VERSION_WIDTH-1:0] oldestVer;
  logic             wrFire;

  logic                     selHit;
  logic [IDX_W-1:0]         selIdx;
  logic [VERSION_WIDTH-1:0] selVersion;

  // Write-side searches all look at pre-edge state only.
  always_comb begin
    matchHit    = 1'b0;
    matchIdx    = '0;
    freeHit     = 1'b0;
    freeIdx     = '0;
    oldestFound = 1'b0;
    oldestIdx   = '0;
    oldestVer   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slotValid[i] && (slotVersion[i] == wrVersion)) begin
        matchHit = 1'b1;
        matchIdx = IDX_W'(i);
      end
      if (!slotValid[i] && !freeHit) begin
        freeHit = 1'b1;
        freeIdx = IDX_W'(i);
      end
      if (slotValid[i] && (!oldestFound || (slotVersion[i] < oldestVer))) begin
        oldestFound = 1'b1;
        oldestIdx   = IDX_W'(i);
        oldestVer   = slotVersion[i];
      end
    end
  end

  assign wrReady = matchHit || freeHit || EVICT_OLDEST;
  assign wrIdx   = matchHit ? matchIdx : (freeHit ? freeIdx : oldestIdx);
  assign wrFire  = wrValid && wrReady;

  // A slot being written survives a same-edge release that would otherwise free it.
  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : gValidNext
    assign validNext[gi] =
        (slotValid[gi] && !(relValid && (slotVersion[gi] < relVersion)))
      || (wrFire && (wrIdx == IDX_W'(gi)));
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      occupancy = occupancy + OCC_W'(slotValid[i]);
    end
  end

  version_select #(
    .NUM_SLOTS    (NUM_SLOTS),
    .VERSION_WIDTH(VERSION_WIDTH)
  ) uReadSelect (
    .slotValid  (slotValid),
    .slotVersion(slotVersion),
    .key        (rdVersion),
    .hit        (selHit),
    .index      (selIdx),
    .version    (selVersion)
  );

  always_ff @(posedge clk) begin
    if (wrFire) begin
      slotData[wrIdx]    <= wrData;
      slotVersion[wrIdx] <= wrVersion;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      slotValid      <= '0;
      rdRespValid    <= 1'b0;
      rdHit          <= 1'b0;
      rdData         <= '0;
      rdMatchVersion <= '0;
    end else begin
      slotValid   <= validNext;
      rdRespValid <= rdValid;
      if (rdValid) begin
        rdHit          <= selHit;
        rdData         <= selHit ? slotData[selIdx] : '0;
        rdMatchVersion <= selHit ? selVersion : '0;
      end
    end
  end

endmodule

// File: tb/tb_versioned_store.sv
// Directed bench: two stores (stall and evict variants) share one stimulus stream.
module tb_versioned_store;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        wrValid = 1'b0;
  logic [3:0]  wrVersion = '0;
  logic [31:0] wrData = '0;
  logic        rdValid = 1'b0;
  logic [3:0]  rdVersion = '0;
  logic        relValid = 1'b0;
  logic [3:0]  relVersion = '0;

  logic        wrReady0, wrReady1;
  logic        rdRespValid0, rdRespValid1;
  logic        rdHit0, rdHit1;
  logic [31:0] rdData0, rdData1;
  logic [3:0]  rdMatchVersion0, rdMatchVersion1;
  logic [2:0]  occupancy0, occupancy1;

  int passCount = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  versioned_store #(.DATA_WIDTH(32), .VERSION_WIDTH(4), .NUM_SLOTS(4), .EVICT_OLDEST(1'b0)) dut0 (
    .clk(clk), .rstN(rstN), .wrValid(wrValid), .wrReady(wrReady0), .wrVersion(wrVersion),
    .wrData(wrData), .rdValid(rdValid), .rdVersion(rdVersion), .rdRespValid(rdRespValid0),
    .rdHit(rdHit0), .rdData(rdData0), .rdMatchVersion(rdMatchVersion0), .relValid(relValid),
    .relVersion(relVersion), .occupancy(occupancy0)
  );

  versioned_store #(.DATA_WIDTH(32), .VERSION_WIDTH(4), .NUM_SLOTS(4), .EVICT_OLDEST(1'b1)) dut1 (
    .clk(clk), .rstN(rstN), .wrValid(wrValid), .wrReady(wrReady1), .wrVersion(wrVersion),
    .wrData(wrData), .rdValid(rdValid), .rdVersion(rdVersion), .rdRespValid(rdRespValid1),
    .rdHit(rdHit1), .rdData(rdData1), .rdMatchVersion(rdMatchVersion1), .relValid(relValid),
    .relVersion(relVersion), .occupancy(occupancy1)
  );

  task automatic doReset();
    @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic doWrite(input logic [3:0] ver, input logic [31:0] data);
    @(negedge clk);
    wrValid = 1'b1; wrVersion = ver; wrData = data;
    @(negedge clk);
    wrValid = 1'b0;
    $display("write v=%0d d=%0d occ0=%0d occ1=%0d", ver, data, occupancy0, occupancy1);
  endtask

  // Leaves the response registered; outputs are sampled on the following negedge.
  task automatic doRead(input logic [3:0] ver);
    @(negedge clk);
    rdValid = 1'b1; rdVersion = ver;
    @(negedge clk);
    rdValid = 1'b0;
    $display("read v=%0d -> dut0 hit=%0d d=%0d mv=%0d | dut1 hit=%0d d=%0d mv=%0d",
             ver, rdHit0, rdData0, rdMatchVersion0, rdHit1, rdData1, rdMatchVersion1);
  endtask

  task automatic doRelease(input logic [3:0] ver);
    @(negedge clk);
    relValid = 1'b1; relVersion = ver;
    @(negedge clk);
    relValid = 1'b0;
    $display("release v<%0d occ0=%0d", ver, occupancy0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstN = 1'b0;
    #1;
    checkCount++;
    if (occupancy0 !== 3'd0) $display("FAIL reset_occ got %0d want 0", occupancy0); else passCount++;
    checkCount++;
    if (rdRespValid0 !== 1'b0 || rdHit0 !== 1'b0) $display("FAIL reset_resp got v=%b h=%b want 0/0", rdRespValid0, rdHit0); else passCount++;
    checkCount++;
    if (rdData0 !== 32'd0 || rdMatchVersion0 !== 4'd0) $display("FAIL reset_data got d=%0d mv=%0d want 0/0", rdData0, rdMatchVersion0); else passCount++;
    checkCount++;
    if (wrReady0 !== 1'b1) $display("FAIL reset_wrready got %b want 1", wrReady0); else passCount++;
    @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic test_basic_read();
    doReset();
    doWrite(4'd3, 32'd100);
    doWrite(4'd7, 32'd200);
    doRead(4'd5);
    checkCount++;
    if (rdRespValid0 !== 1'b1 || rdHit0 !== 1'b1 || rdData0 !== 32'd100 || rdMatchVersion0 !== 4'd3)
      $display("FAIL read5 got v=%b h=%b d=%0d mv=%0d want 1/1/100/3", rdRespValid0, rdHit0, rdData0, rdMatchVersion0);
    else passCount++;
    doRead(4'd9);
    checkCount++;
    if (rdHit0 !== 1'b1 || rdData0 !== 32'd200 || rdMatchVersion0 !== 4'd7)
      $display("FAIL read9 got h=%b d=%0d mv=%0d want 1/200/7", rdHit0, rdData0, rdMatchVersion0);
    else passCount++;
    doRead(4'd2);
    checkCount++;
    if (rdRespValid0 !== 1'b1 || rdHit0 !== 1'b0 || rdData0 !== 32'd0 || rdMatchVersion0 !== 4'd0)
      $display("FAIL read2_miss got v=%b h=%b d=%0d mv=%0d want 1/0/0/0", rdRespValid0, rdHit0, rdData0, rdMatchVersion0);
    else passCount++;
    doRead(4'd7);
    @(negedge clk);
    checkCount++;
    if (rdRespValid0 !== 1'b0 || rdData0 !== 32'd200)
      $display("FAIL idle_hold got v=%b d=%0d want 0/200", rdRespValid0, rdData0);
    else passCount++;
  endtask

  task automatic test_stall();
    doReset();
    for (int v = 1; v <= 4; v++) doWrite(4'(v), 32'(v * 10));
    checkCount++;
    if (occupancy0 !== 3'd4) $display("FAIL full_occ got %0d want 4", occupancy0); else passCount++;
    @(negedge clk);
    wrVersion = 4'd5;
    #1;
    checkCount++;
    if (wrReady0 !== 1'b0 || wrReady1 !== 1'b1) $display("FAIL full_ready got s=%b e=%b want 0/1", wrReady0, wrReady1); else passCount++;
    wrVersion = 4'd2;
    #1;
    checkCount++;
    if (wrReady0 !== 1'b1) $display("FAIL overwrite_ready got %b want 1", wrReady0); else passCount++;
    doWrite(4'd2, 32'd55);
    checkCount++;
    if (occupancy0 !== 3'd4) $display("FAIL overwrite_occ got %0d want 4", occupancy0); else passCount++;
    doRead(4'd2);
    checkCount++;
    if (rdHit0 !== 1'b1 || rdData0 !== 32'd55) $display("FAIL overwrite_read got h=%b d=%0d want 1/55", rdHit0, rdData0); else passCount++;
  endtask

  task automatic test_evict();
    doReset();
    for (int v = 1; v <= 4; v++) doWrite(4'(v), 32'(v * 10));
    doWrite(4'd9, 32'd77);
    checkCount++;
    if (occupancy1 !== 3'd4) $display("FAIL evict_occ got %0d want 4", occupancy1); else passCount++;
    doRead(4'd1);
    checkCount++;
    if (rdHit1 !== 1'b0 || rdData1 !== 32'd0) $display("FAIL evict_read1 got h=%b d=%0d want 0/0", rdHit1, rdData1); else passCount++;
    checkCount++;
    if (rdHit0 !== 1'b1 || rdData0 !== 32'd10) $display("FAIL stall_kept1 got h=%b d=%0d want 1/10", rdHit0, rdData0); else passCount++;
    doRead(4'd15);
    checkCount++;
    if (rdHit1 !== 1'b1 || rdData1 !== 32'd77 || rdMatchVersion1 !== 4'd9)
      $display("FAIL evict_read15 got h=%b d=%0d mv=%0d want 1/77/9", rdHit1, rdData1, rdMatchVersion1);
    else passCount++;
    doRead(4'd2);
    checkCount++;
    if (rdHit1 !== 1'b1 || rdData1 !== 32'd20) $display("FAIL evict_read2 got h=%b d=%0d want 1/20", rdHit1, rdData1); else passCount++;
  endtask

  task automatic test_release();
    doReset();
    doWrite(4'd1, 32'd11);
    doWrite(4'd3, 32'd33);
    doWrite(4'd5, 32'd55);
    doRelease(4'd4);
    checkCount++;
    if (occupancy0 !== 3'd1) $display("FAIL rel_occ got %0d want 1", occupancy0); else passCount++;
    doRead(4'd4);
    checkCount++;
    if (rdHit0 !== 1'b0) $display("FAIL rel_read4 got h=%b want 0", rdHit0); else passCount++;
    doRead(4'd5);
    checkCount++;
    if (rdHit0 !== 1'b1 || rdData0 !== 32'd55) $display("FAIL rel_read5 got h=%b d=%0d want 1/55", rdHit0, rdData0); else passCount++;
    doRelease(4'd0);
    checkCount++;
    if (occupancy0 !== 3'd1) $display("FAIL rel0_occ got %0d want 1", occupancy0); else passCount++;
  endtask

  task automatic test_simultaneous();
    doReset();
    doWrite(4'd2, 32'd22);
    doWrite(4'd5, 32'd50);
    @(negedge clk);
    relValid = 1'b1; relVersion = 4'd6;
    wrValid = 1'b1; wrVersion = 4'd2; wrData = 32'd222;
    rdValid = 1'b1; rdVersion = 4'd5;
    @(negedge clk);
    relValid = 1'b0; wrValid = 1'b0; rdValid = 1'b0;
    $display("simul rel<6 + write v=2 + read v=5 -> d=%0d occ=%0d", rdData0, occupancy0);
    checkCount++;
    if (rdRespValid0 !== 1'b1 || rdHit0 !== 1'b1 || rdData0 !== 32'd50)
      $display("FAIL simul_read got v=%b h=%b d=%0d want 1/1/50", rdRespValid0, rdHit0, rdData0);
    else passCount++;
    checkCount++;
    if (occupancy0 !== 3'd1) $display("FAIL simul_occ got %0d want 1", occupancy0); else passCount++;
    doRead(4'd2);
    checkCount++;
    if (rdHit0 !== 1'b1 || rdData0 !== 32'd222) $display("FAIL simul_kept got h=%b d=%0d want 1/222", rdHit0, rdData0); else passCount++;
    doRead(4'd5);
    checkCount++;
    if (rdHit0 !== 1'b1 || rdData0 !== 32'd222 || rdMatchVersion0 !== 4'd2)
      $display("FAIL simul_freed got h=%b d=%0d mv=%0d want 1/222/2", rdHit0, rdData0, rdMatchVersion0);
    else passCount++;
  endtask

  task automatic test_async_reset();
    doReset();
    doWrite(4'd4, 32'd44);
    @(negedge clk);
    rdValid = 1'b1; rdVersion = 4'd4;
    @(posedge clk);
    #1;
    rdValid = 1'b0;
    checkCount++;
    if (rdRespValid0 !== 1'b1) $display("FAIL inflight_resp got %b want 1", rdRespValid0); else passCount++;
    rstN = 1'b0;
    #1;
    $display("async reset mid-response -> v=%b occ=%0d", rdRespValid0, occupancy0);
    checkCount++;
    if (rdRespValid0 !== 1'b0 || occupancy0 !== 3'd0)
      $display("FAIL async_reset got v=%b occ=%0d want 0/0", rdRespValid0, occupancy0);
    else passCount++;
    @(negedge clk);
    rstN = 1'b1;
    doRead(4'd4);
    checkCount++;
    if (rdRespValid0 !== 1'b1 || rdHit0 !== 1'b0) $display("FAIL post_reset_read got v=%b h=%b want 1/0", rdRespValid0, rdHit0); else passCount++;
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_stall();
    test_evict();
    test_release();
    test_simultaneous();
    test_async_reset();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
